pix_loader: RTL and testbench

Front-end stage of the edge-detection datapath. It receives an 8-bit grayscale pixel stream over a valid/ready handshake and packs four pixels per 32-bit word. It writes the packed words into the shared image memory at the input-image region. Once the full frame is written, it pulses `start` to the edge-detection accelerator and waits for its `finish`.

---
 rtl/edge_pkg.sv | 10 +
 rtl/pix_pack.sv | 42 ++++
 rtl/pix_loader.sv | 100 ++++++++++
 tb/tb_pix_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// edge_pkg: shared frame geometry and loader state encoding for the edge-detection datapath.
package edge_pkg;
    localparam int IMG_W         = 352;
    localparam int IMG_H         = 288;
    localparam int WORDS_PER_ROW = IMG_W / 4;
    localparam int FRAME_WORDS   = WORDS_PER_ROW * IMG_H;
    localparam int RESULT_OFFSET = FRAME_WORDS;

    typedef enum logic [1:0] {IDLE, COLLECT, KICK, WAIT_ACC} loader_state_t;
endpackage

// File: rtl/pix_pack.sv
// pix_pack: packs four accepted bytes into a 32-bit word and holds it in a pending register.
module pix_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        accept,
    input  logic [7:0]  pix_data,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  lane_q, lane_d;
    logic [23:0] bytes_q, bytes_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic        full;

    // Bytes enter at the top and shift down, so the first pixel of a word lands in bits 7:0.
    always_comb begin
        full    = accept && lane_q == 2'd3;
        lane_d  = clr ? 2'd0 : lane_q + 2'(accept);
        bytes_d = accept ? {pix_data, bytes_q[23:8]} : bytes_q;
        word_d  = full ? {pix_data, bytes_q} : word_q;
        valid_d = full && !clr;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q  <= '0;
            bytes_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            bytes_q <= bytes_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    assign word_valid = valid_q;
    assign word       = word_q;
endmodule

// File: rtl/pix_loader.sv
// pix_loader: streams a grayscale frame into image memory as packed words,
// then kicks the edge-detection accelerator and waits for it to finish.
module pix_loader
    import edge_pkg::*;
#(
    parameter int IMG_W     = edge_pkg::IMG_W,
    parameter int IMG_H     = edge_pkg::IMG_H,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    input  logic        pix_last,
    output logic        pix_ready,
    output logic [15:0] addr,
    output logic [31:0] dataW,
    output logic        en,
    output logic        we,
    output logic        bus_own,
    output logic        acc_start,
    input  logic        acc_finish,
    output logic        frame_done,
    output logic        err
);
    localparam int          NPIX      = IMG_W * IMG_H;
    localparam logic [16:0] LAST_PIX  = 17'(NPIX - 1);
    localparam logic [14:0] LAST_WORD = 15'(NPIX / 4 - 1);

    loader_state_t state_q, state_d;
    logic [16:0]   pix_cnt_q, pix_cnt_d;
    logic [14:0]   word_cnt_q, word_cnt_d;
    logic          err_q, err_d, done_q, done_d;
    logic          clr, accept, wr, last_wr;
    logic [31:0]   word;

    pix_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .accept     (accept),
        .pix_data   (pix_data),
        .word_valid (wr),
        .word       (word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = load ? COLLECT : IDLE;
            COLLECT:  state_d = last_wr ? KICK : COLLECT;
            KICK:     state_d = WAIT_ACC;
            WAIT_ACC: state_d = acc_finish ? IDLE : WAIT_ACC;
            default:  state_d = IDLE;
        endcase
    end

    // The frame ends by count; ready falls in the cycle of the final write.
    always_comb begin
        clr        = state_q == IDLE && load;
        last_wr    = wr && word_cnt_q == LAST_WORD;
        pix_ready  = state_q == COLLECT && !last_wr;
        accept     = pix_valid && pix_ready;
        bus_own    = state_q == COLLECT;
        acc_start  = state_q == KICK;
        en         = wr;
        we         = wr;
        addr       = wr ? 16'(BASE_ADDR) + {1'b0, word_cnt_q} : 16'd0;
        dataW      = wr ? word : 32'd0;
        frame_done = done_q;
        err        = err_q;
    end

    always_comb begin
        pix_cnt_d  = clr ? 17'd0 : pix_cnt_q + 17'(accept);
        word_cnt_d = clr ? 15'd0 : word_cnt_q + 15'(wr);
        err_d      = clr ? 1'b0 : err_q | (accept && (pix_last != (pix_cnt_q == LAST_PIX)));
        done_d     = state_q == WAIT_ACC && acc_finish;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_cnt_q  <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: tb/tb_pix_loader.sv
// tb_pix_loader: randomized frame streams checked every cycle against a behavioural
// model of the loader, plus literal expectations on memory contents and pulses.
module tb_pix_loader;
    localparam int W    = 16;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int NW   = NPIX / 4;
    localparam int BASE = 0;

    logic        clk = 0, reset = 0, load = 0, pix_valid = 0, pix_last = 0, acc_finish = 0;
    logic [7:0]  pix_data = 0;
    logic        pix_ready, en, we, bus_own, acc_start, frame_done, err;
    logic [15:0] addr;
    logic [31:0] dataW;

    always #5 clk = ~clk;

    pix_loader #(.IMG_W(W), .IMG_H(H), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_ready  (pix_ready),
        .addr       (addr),
        .dataW      (dataW),
        .en         (en),
        .we         (we),
        .bus_own    (bus_own),
        .acc_start  (acc_start),
        .acc_finish (acc_finish),
        .frame_done (frame_done),
        .err        (err)
    );

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural model: which phase the frame is in, how many pixels were taken,
    // and which word (if any) must be on the bus this cycle.
    bit           m_coll = 0, m_kick = 0, m_wait = 0, m_done = 0, m_err = 0, m_pend = 0;
    int           m_acc = 0, m_pidx = 0;
    logic [7:0]   m_pix [NPIX];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_coll = 0; m_kick = 0; m_wait = 0; m_done = 0; m_err = 0; m_pend = 0;
            m_acc = 0; m_pidx = 0;
        end else begin
            bit idle, a, wr_last;
            idle    = !m_coll && !m_kick && !m_wait;
            a       = m_coll && m_acc < NPIX && pix_valid;
            wr_last = m_pend && m_pidx == NW - 1;
            m_done  = m_wait && acc_finish;
            m_wait  = (m_wait && !acc_finish) || m_kick;
            m_kick  = wr_last;
            if (wr_last) m_coll = 0;
            m_pend  = a && m_acc % 4 == 3;
            if (a) begin
                m_pix[m_acc] = pix_data;
                if (pix_last != (m_acc == NPIX - 1)) m_err = 1;
                if (m_acc % 4 == 3) m_pidx = m_acc / 4;
                m_acc++;
            end
            if (idle && load) begin
                m_coll = 1; m_acc = 0; m_err = 0;
            end
        end
    end

    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            logic [31:0] ed;
            ed = m_pend ? {m_pix[4*m_pidx+3], m_pix[4*m_pidx+2], m_pix[4*m_pidx+1], m_pix[4*m_pidx]} : 32'd0;
            chk("pix_ready", 32'(pix_ready), 32'(m_coll && m_acc < NPIX));
            chk("en", 32'(en), 32'(m_pend));
            chk("we", 32'(we), 32'(m_pend));
            chk("addr", 32'(addr), m_pend ? 32'(BASE + m_pidx) : 32'd0);
            chk("dataW", dataW, ed);
            chk("bus_own", 32'(bus_own), 32'(m_coll));
            chk("acc_start", 32'(acc_start), 32'(m_kick));
            chk("frame_done", 32'(frame_done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
        end
    end

    // Bus monitor: captured memory image and event counts.
    logic [31:0] mem [NW];
    logic [31:0] ref_mem [NW];
    int wcount = 0, starts = 0, last_addr = -1, first_addr = -1;
    always @(negedge clk) begin
        if (en && we) begin
            if (int'(addr) < NW) mem[addr] = dataW;
            if (wcount == 0) first_addr = int'(addr);
            last_addr = int'(addr);
            wcount++;
        end
        if (acc_start) starts++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        foreach (mem[i]) mem[i] = '0;
        wcount = 0; starts = 0; first_addr = -1;
    endtask

    task automatic do_load;
        load = 1;
        tick;
        load = 0;
    endtask

    task automatic stream(input int mode, input int last_at, input int stop_at);
        int idx = 0, budget = 0;
        bit will;
        while (idx < stop_at && budget < 4000) begin
            pix_valid = mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
            pix_data  = 8'(idx);
            pix_last  = idx == last_at;
            will      = pix_valid && pix_ready;
            tick;
            budget++;
            if (will) idx++;
        end
        pix_valid = 0;
        pix_last  = 0;
        if (idx < stop_at) chk("stream_timeout", 32'(idx), 32'(stop_at));
    endtask

    task automatic wait_start;
        int b = 0;
        while (!acc_start && b < 200) begin tick; b++; end
        chk("acc_start_seen", 32'(acc_start), 32'd1);
    endtask

    task automatic wait_done;
        int b = 0;
        while (!frame_done && b < 200) begin tick; b++; end
        chk("frame_done_seen", 32'(frame_done), 32'd1);
        tick;
        chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
        chk("idle_after_done", 32'(pix_ready), 32'd0);
        acc_finish = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int diffs;
        repeat (3) @(posedge clk);
        #1;
        chk_on = 1;
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_dataW", dataW, 32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        chk("rst_bus_own", 32'(bus_own), 32'd0);
        chk("rst_acc_start", 32'(acc_start), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1;
        tick;

        // Continuous stream, value = index mod 256.
        clear_mon;
        do_load;
        stream(0, NPIX - 1, NPIX);
        wait_start;
        repeat (3) tick;
        acc_finish = 1;
        wait_done;
        chk("t1_word0", mem[0], 32'h03020100);
        chk("t1_wordlast", mem[NW-1], 32'h7F7E7D7C);
        chk("t1_writes", 32'(wcount), 32'(NW));
        chk("t1_starts", 32'(starts), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        foreach (mem[i]) ref_mem[i] = mem[i];

        // Random 50% valid, accelerator finish already high when waiting starts.
        clear_mon;
        do_load;
        stream(1, NPIX - 1, NPIX);
        wait_start;
        acc_finish = 1;
        wait_done;
        diffs = 0;
        foreach (mem[i]) if (mem[i] !== ref_mem[i]) diffs++;
        chk("t2_mem_diffs", 32'(diffs), 32'd0);
        chk("t2_writes", 32'(wcount), 32'(NW));
        chk("t2_starts", 32'(starts), 32'd1);

        // Early pix_last on pixel 40: frame still completes by count.
        clear_mon;
        do_load;
        stream(0, 40, NPIX);
        chk("t3_err_set", 32'(err), 32'd1);
        wait_start;
        repeat (2) tick;
        acc_finish = 1;
        wait_done;
        chk("t3_writes", 32'(wcount), 32'(NW));
        chk("t3_err_held", 32'(err), 32'd1);
        do_load;
        chk("t3_err_cleared", 32'(err), 32'd0);

        // Reset after 41 accepted pixels: partial word 10 is dropped.
        clear_mon;
        stream(0, NPIX - 1, 41);
        reset = 0;
        #1;
        chk("t4_en", 32'(en), 32'd0);
        chk("t4_addr", 32'(addr), 32'd0);
        chk("t4_dataW", dataW, 32'd0);
        chk("t4_pix_ready", 32'(pix_ready), 32'd0);
        chk("t4_bus_own", 32'(bus_own), 32'd0);
        #2;
        reset = 1;
        repeat (3) tick;
        chk("t4_last_addr", 32'(last_addr), 32'd9);
        chk("t4_writes", 32'(wcount), 32'd10);

        // Fresh frame; load during WAIT_ACC is ignored, finish 50 cycles after start.
        clear_mon;
        do_load;
        stream(1, NPIX - 1, NPIX);
        chk("t5_first_addr", 32'(first_addr), 32'(BASE));
        wait_start;
        repeat (20) tick;
        load = 1;
        tick;
        load = 0;
        repeat (29) tick;
        acc_finish = 1;
        tick;
        chk("t5_done_next", 32'(frame_done), 32'd1);
        wait_done;
        chk("t5_starts", 32'(starts), 32'd1);
        chk("t5_writes", 32'(wcount), 32'(NW));
        repeat (3) tick;
        chk("t5_still_idle", 32'(bus_own), 32'd0);

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
